game_state_ctrl: RTL and testbench

- Downstream of the ball and wall movers; consumes ball position and wall geometry once per frame.
- Detects collisions with the wall and floor, runs the game FSM (IDLE/PLAY/HIT/OVER) and keeps a 2-digit BCD score.
- Drives ball_reset back into the mover's reset button input, and drives the score and state outputs to the renderer.

---
 rtl/game_state_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//   Once-per-frame game controller. Detects ball/wall and ball/floor
//   collisions, runs the IDLE/PLAY/HIT/OVER game FSM and keeps a saturating
//   2-digit BCD score. All state advances only on the frame tick
//   (h_counter==0 && v_counter==0); on every other clock it holds.
//
// Optional feature macro: GAME_STATE_HISCORE_EN
//   When defined, adds a BCD high-score output latched on PLAY->HIT.
//
// Ports
//   clk        in   pixel clock
//   rst        in   asynchronous active-high reset
//   h_counter  in   [9:0] horizontal pixel counter
//   v_counter  in   [9:0] vertical line counter
//   flap       in   jump button
//   restart    in   restart button
//   ballX/Y    in   [9:0] ball top-left corner
//   wallX      in   [9:0] wall left edge
//   wallY      in   [9:0] wall top edge
//   wallBaseX  in   [9:0] wall width
//   wallBaseY  in   [9:0] wall bottom edge
//   state      out  [1:0] 00 IDLE, 01 PLAY, 10 HIT, 11 OVER
//   ball_reset out  holds the ball mover in its reset position (IDLE)
//   freeze     out  renderer stops scrolling (HIT, OVER)
//   score      out  [7:0] BCD, [7:4] tens, [3:0] units
//   collision  out  collision flag of the last evaluated frame
//   hiscore    out  [7:0] BCD best score (GAME_STATE_HISCORE_EN only)
// ---------------------------------------------------------------------------
module game_state_ctrl #(
  parameter int BALL_SIZE  = 10,
  parameter int FLOOR_Y    = 490,
  parameter int HIT_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  input  logic       flap,
  input  logic       restart,
  input  logic [9:0] ballX,
  input  logic [9:0] ballY,
  input  logic [9:0] wallX,
  input  logic [9:0] wallY,
  input  logic [9:0] wallBaseX,
  input  logic [9:0] wallBaseY,
  output logic [1:0] state,
  output logic       ball_reset,
  output logic       freeze,
  output logic [7:0] score,
  output logic       collision
`ifdef GAME_STATE_HISCORE_EN
  ,
  output logic [7:0] hiscore
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } state_t;

  localparam int HC_W = $clog2(HIT_FRAMES) + 1;
  localparam logic [HC_W-1:0] HIT_LAST = HC_W'(HIT_FRAMES - 1);

  // BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'h9) begin
      r = {v[7:4] + 4'h1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [7:0]      score_r, score_nxt_s;
  logic            passed_r, passed_nxt_s;
  logic [HC_W-1:0] hit_cnt_r, hit_cnt_nxt_s;
  logic            collision_r, collision_nxt_s;
  logic            flap_prev_r, flap_prev_nxt_s;
  logic            restart_prev_r, restart_prev_nxt_s;
  logic            ball_reset_r, freeze_r;
  logic            ball_reset_nxt_s, freeze_nxt_s;
`ifdef GAME_STATE_HISCORE_EN
  logic [7:0]      hiscore_r, hiscore_nxt_s;
`endif

  logic            frame_tick_s;
  logic            flap_edge_s, restart_edge_s;
  logic [10:0]     ball_right_s, ball_bottom_s, wall_right_s;
  logic            wall_hit_s, floor_hit_s, coll_s;
  logic            pass_s, respawn_s;

  assign frame_tick_s   = (h_counter == 10'd0) && (v_counter == 10'd0);
  assign flap_edge_s    = flap && !flap_prev_r;
  assign restart_edge_s = restart && !restart_prev_r;

  // 11-bit sums so right/bottom edges near 1023 do not wrap.
  assign ball_right_s  = {1'b0, ballX} + 11'(BALL_SIZE);
  assign ball_bottom_s = {1'b0, ballY} + 11'(BALL_SIZE);
  assign wall_right_s  = {1'b0, wallX} + {1'b0, wallBaseX};

  assign wall_hit_s  = (ball_right_s > {1'b0, wallX}) &&
                       ({1'b0, ballX} < wall_right_s) &&
                       (ball_bottom_s > {1'b0, wallY}) &&
                       (ballY < wallBaseY);
  assign floor_hit_s = ({1'b0, ballY} > 11'(FLOOR_Y));
  assign coll_s      = wall_hit_s || floor_hit_s;

  // Wall fully left of the ball scores; wall right of the ball means it respawned.
  assign pass_s    = (wall_right_s < {1'b0, ballX});
  assign respawn_s = (wallX > ballX);

  // Next-state, score, pass and hit-counter logic; everything holds off-tick.
  always_comb begin
    state_nxt_s        = state_r;
    score_nxt_s        = score_r;
    passed_nxt_s       = passed_r;
    hit_cnt_nxt_s      = hit_cnt_r;
    collision_nxt_s    = collision_r;
    flap_prev_nxt_s    = flap_prev_r;
    restart_prev_nxt_s = restart_prev_r;
`ifdef GAME_STATE_HISCORE_EN
    hiscore_nxt_s      = hiscore_r;
`endif
    if (frame_tick_s) begin
      collision_nxt_s    = coll_s;
      flap_prev_nxt_s    = flap;
      restart_prev_nxt_s = restart;
      case (state_r)
        ST_IDLE: begin
          if (flap_edge_s) begin
            state_nxt_s  = ST_PLAY;
            score_nxt_s  = 8'h00;
            passed_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_PLAY: begin
          // A collision in the same frame as a pass wins; no point scored.
          if (coll_s) begin
            state_nxt_s   = ST_HIT;
            hit_cnt_nxt_s = {HC_W{1'b0}};
`ifdef GAME_STATE_HISCORE_EN
            if (score_r > hiscore_r) begin
              hiscore_nxt_s = score_r;
            end else begin
              hiscore_nxt_s = hiscore_r;
            end
`endif
          end else if (!passed_r && pass_s) begin
            score_nxt_s  = bcd_inc_sat(score_r);
            passed_nxt_s = 1'b1;
          end else if (respawn_s) begin
            passed_nxt_s = 1'b0;
          end else begin
            passed_nxt_s = passed_r;
          end
        end
        ST_HIT: begin
          if (hit_cnt_r == HIT_LAST) begin
            state_nxt_s = ST_OVER;
          end else begin
            hit_cnt_nxt_s = hit_cnt_r + {{(HC_W-1){1'b0}}, 1'b1};
          end
        end
        ST_OVER: begin
          if (restart_edge_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_OVER;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
    // Decoded from the next state so they register together with it.
    ball_reset_nxt_s = (state_nxt_s == ST_IDLE);
    freeze_nxt_s     = (state_nxt_s == ST_HIT) || (state_nxt_s == ST_OVER);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      score_r        <= 8'h00;
      passed_r       <= 1'b0;
      hit_cnt_r      <= {HC_W{1'b0}};
      collision_r    <= 1'b0;
      flap_prev_r    <= 1'b0;
      restart_prev_r <= 1'b0;
      ball_reset_r   <= 1'b1;
      freeze_r       <= 1'b0;
`ifdef GAME_STATE_HISCORE_EN
      hiscore_r      <= 8'h00;
`endif
    end else begin
      state_r        <= state_nxt_s;
      score_r        <= score_nxt_s;
      passed_r       <= passed_nxt_s;
      hit_cnt_r      <= hit_cnt_nxt_s;
      collision_r    <= collision_nxt_s;
      flap_prev_r    <= flap_prev_nxt_s;
      restart_prev_r <= restart_prev_nxt_s;
      ball_reset_r   <= ball_reset_nxt_s;
      freeze_r       <= freeze_nxt_s;
`ifdef GAME_STATE_HISCORE_EN
      hiscore_r      <= hiscore_nxt_s;
`endif
    end
  end

  assign state      = state_r;
  assign ball_reset = ball_reset_r;
  assign freeze     = freeze_r;
  assign score      = score_r;
  assign collision  = collision_r;
`ifdef GAME_STATE_HISCORE_EN
  assign hiscore    = hiscore_r;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h_counter = 10'd1, v_counter = 10'd0;
  logic       flap = 1'b0, restart = 1'b0;
  logic [9:0] ballX = 10'd600, ballY = 10'd200;
  logic [9:0] wallX = 10'd800, wallY = 10'd370, wallBaseX = 10'd40, wallBaseY = 10'd550;
  logic [1:0] state;
  logic       ball_reset, freeze, collision;
  logic [7:0] score;
`ifdef GAME_STATE_HISCORE_EN
  logic [7:0] hiscore;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state (integer score, plain mode number)
  int m_st, m_sc, m_hs, m_hc;
  bit m_passed, m_coll, m_fp, m_rp;

  always #5 clk = ~clk;

  game_state_ctrl dut (
    .clk(clk), .rst(rst), .h_counter(h_counter), .v_counter(v_counter),
    .flap(flap), .restart(restart), .ballX(ballX), .ballY(ballY),
    .wallX(wallX), .wallY(wallY), .wallBaseX(wallBaseX), .wallBaseY(wallBaseY),
    .state(state), .ball_reset(ball_reset), .freeze(freeze), .score(score),
    .collision(collision)
`ifdef GAME_STATE_HISCORE_EN
    , .hiscore(hiscore)
`endif
  );

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic model_reset();
    m_st = 0; m_sc = 0; m_hs = 0; m_hc = 0;
    m_passed = 0; m_coll = 0; m_fp = 0; m_rp = 0;
  endtask

  // One frame of game rules applied to the current input values.
  task automatic model_step();
    int bx, by, wx, wy, wbx, wby;
    bit c, fe, re;
    bx = int'(ballX); by = int'(ballY); wx = int'(wallX); wy = int'(wallY);
    wbx = int'(wallBaseX); wby = int'(wallBaseY);
    c = ((bx + 10 > wx) && (bx < wx + wbx) && (by + 10 > wy) && (by < wby)) || (by > 490);
    fe = flap && !m_fp;
    re = restart && !m_rp;
    if (m_st == 0) begin
      if (fe) begin m_st = 1; m_sc = 0; m_passed = 0; end
    end else if (m_st == 1) begin
      if (c) begin
        if (m_sc > m_hs) m_hs = m_sc;
        m_st = 2; m_hc = 0;
      end else if (!m_passed && (wx + wbx < bx)) begin
        if (m_sc < 99) m_sc++;
        m_passed = 1;
      end else if (wx > bx) begin
        m_passed = 0;
      end
    end else if (m_st == 2) begin
      m_hc++;
      if (m_hc == 60) m_st = 3;
    end else begin
      if (re) m_st = 0;
    end
    m_coll = c; m_fp = flap; m_rp = restart;
  endtask

  task automatic check_model(input string nm);
    chk({nm, ".state"}, {14'd0, state}, 16'(m_st));
    chk({nm, ".ball_reset"}, {15'd0, ball_reset}, 16'(m_st == 0));
    chk({nm, ".freeze"}, {15'd0, freeze}, 16'(m_st >= 2));
    chk({nm, ".score"}, {8'd0, score}, 16'(to_bcd(m_sc)));
    chk({nm, ".collision"}, {15'd0, collision}, 16'(m_coll));
`ifdef GAME_STATE_HISCORE_EN
    chk({nm, ".hiscore"}, {8'd0, hiscore}, 16'(to_bcd(m_hs)));
`endif
  endtask

  // Drive one frame tick with the given inputs, then leave the tick position.
  task automatic frame(input bit f, input bit r, input int bx, input int by,
                       input int wx, input int wbx, input int wy, input int wby);
    @(negedge clk);
    flap = f; restart = r;
    ballX = 10'(bx); ballY = 10'(by); wallX = 10'(wx);
    wallBaseX = 10'(wbx); wallY = 10'(wy); wallBaseY = 10'(wby);
    h_counter = 10'd0; v_counter = 10'd0;
    @(posedge clk);
    #1;
    h_counter = 10'd1;
    model_step();
  endtask

  task automatic frame_std(input bit f, input bit r, input int bx, input int by, input int wx);
    frame(f, r, bx, by, wx, 40, 370, 550);
  endtask

  // Non-tick cycles with noisy inputs: nothing may change.
  task automatic noise(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) begin
        h_counter = 10'd0; v_counter = 10'($urandom_range(1, 1023));
      end else begin
        h_counter = 10'($urandom_range(1, 1023)); v_counter = 10'($urandom_range(0, 1023));
      end
      flap = 1'($urandom_range(0, 1)); restart = 1'($urandom_range(0, 1));
      ballX = 10'($urandom_range(0, 1023)); ballY = 10'($urandom_range(0, 1023));
      @(posedge clk);
    end
    #1;
    h_counter = 10'd1;
  endtask

  // From HIT entry: 59 more frames stay in HIT, the 60th reaches OVER.
  task automatic hit_to_over(input string nm, input int bx, input int by, input int wx);
    for (int i = 1; i <= 60; i++) begin
      frame_std(0, 0, bx, by, wx);
      if (i == 59) chk({nm, ".hit_last"}, {14'd0, state}, 16'd2);
    end
    chk({nm, ".over"}, {14'd0, state}, 16'd3);
    chk({nm, ".over_freeze"}, {15'd0, freeze}, 16'd1);
  endtask

  typedef struct {
    bit f; bit r; int bx; int by; int wx;
    int e_state; int e_score; bit e_coll;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{0, 0, 600, 200, 800, 0, 'h00, 0};
    tbl[1]  = '{0, 0, 600, 200, 800, 0, 'h00, 0};
    tbl[2]  = '{0, 0, 600, 200, 800, 0, 'h00, 0};
    tbl[3]  = '{1, 0, 600, 200, 800, 1, 'h00, 0};
    tbl[4]  = '{0, 0, 600, 200, 650, 1, 'h00, 0};
    tbl[5]  = '{0, 0, 600, 200, 600, 1, 'h00, 0};
    tbl[6]  = '{0, 0, 600, 200, 570, 1, 'h00, 0};
    tbl[7]  = '{0, 0, 600, 200, 559, 1, 'h01, 0};
    tbl[8]  = '{0, 0, 600, 200, 540, 1, 'h01, 0};
    tbl[9]  = '{0, 0, 600, 200, 800, 1, 'h01, 0};
    tbl[10] = '{0, 0, 600, 200, 650, 1, 'h01, 0};
    tbl[11] = '{0, 0, 600, 200, 555, 1, 'h02, 0};
    tbl[12] = '{0, 0, 600, 200, 540, 1, 'h02, 0};
    tbl[13] = '{0, 0, 600, 400, 595, 2, 'h02, 1};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.state", {14'd0, state}, 16'd0);
    chk("reset.ball_reset", {15'd0, ball_reset}, 16'd1);

    // Start a game, then reset asynchronously mid-cycle.
    frame_std(1, 0, 600, 200, 800);
    chk("pre_rst.state", {14'd0, state}, 16'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst.state", {14'd0, state}, 16'd0);
    chk("async_rst.ball_reset", {15'd0, ball_reset}, 16'd1);
    chk("async_rst.freeze", {15'd0, freeze}, 16'd0);
    chk("async_rst.score", {8'd0, score}, 16'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    flap = 1'b0;

    // Directed table: idle, start, two wall passes, wall collision.
    for (int i = 0; i < 14; i++) begin
      frame_std(tbl[i].f, tbl[i].r, tbl[i].bx, tbl[i].by, tbl[i].wx);
      chk($sformatf("tbl%0d.state", i), {14'd0, state}, 16'(tbl[i].e_state));
      chk($sformatf("tbl%0d.score", i), {8'd0, score}, 16'(tbl[i].e_score));
      chk($sformatf("tbl%0d.coll", i), {15'd0, collision}, 16'(tbl[i].e_coll));
      chk($sformatf("tbl%0d.ball_reset", i), {15'd0, ball_reset}, 16'(tbl[i].e_state == 0));
      chk($sformatf("tbl%0d.freeze", i), {15'd0, freeze}, 16'(tbl[i].e_state >= 2));
    end
    hit_to_over("wallhit", 600, 400, 595);
    check_model("wallhit_model");

    // flap ignored in OVER; restart edge returns to IDLE.
    frame_std(1, 0, 600, 200, 800);
    chk("over_flap.state", {14'd0, state}, 16'd3);
    frame_std(0, 0, 600, 200, 800);
    frame_std(0, 1, 600, 200, 800);
    chk("restart.state", {14'd0, state}, 16'd0);
    chk("restart.ball_reset", {15'd0, ball_reset}, 16'd1);
    chk("restart.score_held", {8'd0, score}, 16'h02);

    // Game with score 07 ending on the floor.
    frame_std(1, 0, 600, 200, 800);
    for (int p = 0; p < 7; p++) begin
      frame_std(0, 0, 600, 200, 800);
      frame_std(0, 0, 600, 200, 540);
    end
    chk("seven.score", {8'd0, score}, 16'h07);
    frame_std(0, 0, 600, 490, 800);
    chk("floor490.state", {14'd0, state}, 16'd1);
    chk("floor490.coll", {15'd0, collision}, 16'd0);
    frame_std(0, 0, 600, 491, 800);
    chk("floor491.state", {14'd0, state}, 16'd2);
    chk("floor491.coll", {15'd0, collision}, 16'd1);
`ifdef GAME_STATE_HISCORE_EN
    chk("hiscore07", {8'd0, hiscore}, 16'h07);
`endif
    hit_to_over("floor", 600, 491, 800);
    frame_std(0, 1, 600, 200, 800);
    chk("restart2.state", {14'd0, state}, 16'd0);

    // BCD carry and saturation over 100 passes.
    frame_std(1, 0, 600, 200, 800);
    for (int p = 1; p <= 100; p++) begin
      frame_std(0, 0, 600, 200, 800);
      frame_std(0, 0, 600, 200, 540);
      if (p == 10) chk("bcd10", {8'd0, score}, 16'h10);
      if (p == 99) chk("bcd99", {8'd0, score}, 16'h99);
      if (p == 100) chk("sat100", {8'd0, score}, 16'h99);
    end
    frame_std(0, 0, 600, 491, 800);
    check_model("sat_hit");
    hit_to_over("sat", 600, 491, 800);
    frame_std(0, 1, 600, 200, 800);
    check_model("sat_restart");

    // Randomized frames against the reference model.
    for (int n = 0; n < 1500; n++) begin
      int wy;
      noise($urandom_range(0, 2));
      check_model("hold");
      if ($urandom_range(0, 199) == 0) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_model("rand_rst");
        @(negedge clk);
        rst = 1'b0;
        flap = 1'b0; restart = 1'b0;
      end
      wy = $urandom_range(200, 500);
      frame($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(300, 700),
            ($urandom_range(0, 9) == 0) ? $urandom_range(480, 520) : $urandom_range(100, 480),
            $urandom_range(0, 1023), $urandom_range(10, 80), wy, $urandom_range(wy, 1023));
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
